if_id_skid_reg: RTL and testbench

Parametrised successor to the fetch/decode pipeline register. It adds a valid/ready handshake on both sides and a 2-entry skid buffer, so fetch and decode can each stall without a combinational ready path. Flush squashes all in-flight entries, and empty slots present a configurable NOP to decode. It sits between the IF and ID stages; the same block serves any PC+instruction stage boundary.

---
 rtl/if_id_skid_reg.sv | 154 +++++++++++++++
 tb/tb_if_id_skid_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID pipeline register with valid/ready handshake and 2-entry skid buffer
//
// Purpose:
//   Holds one fetched PC/instruction pair for decode (main entry) plus one spare
//   slot (skid entry). The spare slot lets fetch keep running for one cycle after
//   decode stalls. Because of it, in_ready comes straight from a flop and has no
//   combinational path from out_ready. Flush squashes both entries. An empty head
//   presents NOP_INSTR to decode.
//
// Optional feature:
//   IF_ID_PERF_CNT_EN - when defined, adds saturating stall_cnt / flush_cnt outputs.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   flush      squash all held entries; any same-cycle input transfer is dropped
//   in_valid   fetch presents in_pc / in_instr
//   in_ready   block can accept; registered, equals !skid_valid
//   in_pc      fetched PC
//   in_instr   fetched instruction
//   out_valid  head entry valid
//   out_ready  decode consumes the head entry
//   out_pc     PC of head entry (last loaded value when out_valid=0)
//   out_instr  head instruction, NOP_INSTR when out_valid=0
//   stall_cnt  (IF_ID_PERF_CNT_EN) cycles with out_valid=1 and out_ready=0
//   flush_cnt  (IF_ID_PERF_CNT_EN) flush cycles that squashed at least one entry

module if_id_skid_reg #(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h0000_0013,
  parameter logic [PC_W-1:0]      RESET_PC  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  logic               main_valid_q, main_valid_d;
  logic [PC_W-1:0]    main_pc_q,    main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic               skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

  logic in_fire;
  logic out_fire;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_pc    = main_pc_q;
  assign out_instr = main_valid_q ? main_instr_q : NOP_INSTR;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      // main_pc is deliberately kept so out_pc does not glitch on a redirect
      main_valid_d = 1'b0;
      main_instr_d = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only the drain path can move data
      if (out_fire) begin
        main_valid_d = 1'b1;
        main_pc_d    = skid_pc_q;
        main_instr_d = skid_instr_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || out_fire) begin
      // head is empty or leaving this cycle: input goes straight to main
      main_valid_d = in_fire;
      if (in_fire) begin
        main_pc_d    = in_pc;
        main_instr_d = in_instr;
      end
    end else if (in_fire) begin
      // head is stuck: park the new entry in the skid slot
      skid_valid_d = 1'b1;
      skid_pc_d    = in_pc;
      skid_instr_d = in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= RESET_PC;
      main_instr_q <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    // only flushes that actually squash something are interesting
    if (flush && (main_valid_q || skid_valid_q) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - self-checking bench for if_id_skid_reg

module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc     = 32'd0;
  logic [31:0] in_instr  = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int n_run  = 0;
  int n_fail = 0;

  // scoreboard: {pc, instr} of every entry the block should currently hold, head first
  logic [63:0] sb[$];
  // PCs actually handed to decode (out_valid & out_ready seen on the DUT)
  logic [31:0] seen[$];

  always #5 clk = ~clk;

  if_id_skid_reg dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return (pc << 8) ^ 32'h0000_0093;
  endfunction

  // Called at a negedge: applies inputs, advances the scoreboard across the
  // coming rising edge, and returns at the following negedge.
  task automatic drive(input logic v, input logic [31:0] pc, input logic ordy,
                       input logic fl, input logic rst);
    logic accept;
    logic pop;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = mk_instr(pc);
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    accept = v && (sb.size() < 2);
    pop    = (sb.size() > 0) && ordy;
    if (out_valid && ordy && rst && !fl) seen.push_back(out_pc);
    if (!rst || fl) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (accept) sb.push_back({pc, mk_instr(pc)});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    in_valid = 1'b0;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    n_run++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc got %h exp 00000000", out_pc); end
    n_run++; if (out_instr !== NOP) begin n_fail++; $display("FAIL reset_out_instr got %h exp %h", out_instr, NOP); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 32'(i * 4), 1'b1, 1'b0, 1'b1);
      if (i < 3) begin
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %0b exp 1", i, out_valid); end
        n_run++; if (out_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL stream_pc[%0d] got %h exp %h", i, out_pc, 32'(i * 4)); end
        n_run++; if (out_instr !== sb[0][31:0]) begin n_fail++; $display("FAIL stream_instr[%0d] got %h exp %h", i, out_instr, sb[0][31:0]); end
      end else begin
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained got %0b exp 0", out_valid); end
        n_run++; if (out_instr !== NOP) begin n_fail++; $display("FAIL stream_nop got %h exp %h", out_instr, NOP); end
      end
      n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %0b exp 1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_seq [3];
    exp_seq = '{32'h10, 32'h14, 32'h18};
    seen.delete();
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b1);
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one got %0b exp 1", in_ready); end
    drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b1);
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %0b exp 0", in_ready); end
    drive(1'b1, 32'h18, 1'b0, 1'b0, 1'b1);
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_hold got %0b exp 0", in_ready); end
    n_run++; if (out_pc !== 32'h10 || out_instr !== mk_instr(32'h10)) begin n_fail++; $display("FAIL bp_head_stable got %h/%h exp 00000010/%h", out_pc, out_instr, mk_instr(32'h10)); end
    drive(1'b1, 32'h18, 1'b1, 1'b0, 1'b1);
    n_run++; if (out_pc !== 32'h14 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain1 got pc %h rdy %0b exp 00000014 1", out_pc, in_ready); end
    drive(1'b1, 32'h18, 1'b1, 1'b0, 1'b1);
    n_run++; if (out_pc !== 32'h18 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain2 got pc %h v %0b exp 00000018 1", out_pc, out_valid); end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %0b exp 0", out_valid); end
    n_run++; if (seen.size() != 3) begin n_fail++; $display("FAIL bp_count got %0d exp 3", seen.size()); end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      n_run++; if (seen[i] !== exp_seq[i]) begin n_fail++; $display("FAIL bp_order[%0d] got %h exp %h", i, seen[i], exp_seq[i]); end
    end
  endtask

  task automatic test_flush();
    seen.delete();
    drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h24, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h28, 1'b0, 1'b1, 1'b1);
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b exp 0", out_valid); end
    n_run++; if (out_instr !== NOP) begin n_fail++; $display("FAIL flush_instr got %h exp %h", out_instr, NOP); end
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %0b exp 1", in_ready); end
    n_run++; if (out_pc !== 32'h20) begin n_fail++; $display("FAIL flush_pc_held got %h exp 00000020", out_pc); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d] got %0b exp 0", i, out_valid); end
    end
    n_run++; if (seen.size() != 0) begin n_fail++; $display("FAIL flush_leak got %0d exp 0", seen.size()); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'h1000;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0), 1'b1);
      pc = pc + 32'd4;
      n_run++; if (out_valid !== (sb.size() > 0)) begin n_fail++; $display("FAIL rand_valid[%0d] got %0b exp %0b", i, out_valid, sb.size() > 0); end
      n_run++; if (in_ready !== (sb.size() < 2)) begin n_fail++; $display("FAIL rand_ready[%0d] got %0b exp %0b", i, in_ready, sb.size() < 2); end
      if (sb.size() > 0) begin
        n_run++; if ({out_pc, out_instr} !== sb[0]) begin n_fail++; $display("FAIL rand_head[%0d] got %h exp %h", i, {out_pc, out_instr}, sb[0]); end
      end else begin
        n_run++; if (out_instr !== NOP) begin n_fail++; $display("FAIL rand_nop[%0d] got %h exp %h", i, out_instr, NOP); end
      end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h34, 1'b0, 1'b0, 1'b1);
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rms_full got %0b exp 0", in_ready); end
    drive(1'b1, 32'h38, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    in_valid = 1'b0;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rms_out_valid got %0b exp 0", out_valid); end
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rms_in_ready got %0b exp 1", in_ready); end
    n_run++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rms_out_pc got %h exp 00000000", out_pc); end
    n_run++; if (out_instr !== NOP) begin n_fail++; $display("FAIL rms_out_instr got %h exp %h", out_instr, NOP); end
  endtask

`ifdef IF_ID_PERF_CNT_EN
  task automatic test_perf_cnt();
    drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_run++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL perf_stall got %0d exp 5", stall_cnt); end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    n_run++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL perf_stall_after_flush got %0d exp 5", stall_cnt); end
    n_run++; if (flush_cnt !== 32'd1) begin n_fail++; $display("FAIL perf_flush got %0d exp 1", flush_cnt); end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    n_run++; if (flush_cnt !== 32'd1) begin n_fail++; $display("FAIL perf_flush_empty got %0d exp 1", flush_cnt); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid_stall();
`ifdef IF_ID_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
